// File: rtl/vx_tag_pkg.sv
// Shared types for the set-associative tag store and its victim selector.
// tag_entry_t is laid out for the default tag width.
package vx_tag_pkg;

  localparam int unsigned VX_TAG_WIDTH = 20;

  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [VX_TAG_WIDTH-1:0] tag;
  } tag_entry_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fsm_state_t;

  // Way index width; a direct-mapped bank still carries a 1-bit way field.
  function automatic int unsigned way_bits(input int unsigned num_ways);
    return (num_ways > 32'd1) ? $clog2(num_ways) : 32'd1;
  endfunction

endpackage

// File: rtl/VX_sp_ram.sv
// Single-port storage array: asynchronous read and synchronous write at one address.
module VX_sp_ram #(
  parameter int unsigned DATAW      = 1,
  parameter int unsigned SIZE       = 2,
  parameter bit          NO_RWCHECK = 1'b0,
  localparam int unsigned ADDRW     = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             write,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] wdata,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem_q [SIZE];

  // Write port; contents are not reset, the owner initialises them.
  always_ff @(posedge clk) begin
    if (en && write) begin
      mem_q[addr] <= wdata;
    end
  end

  // With NO_RWCHECK a read during a write returns the old contents.
  assign rdata = (!NO_RWCHECK && en && write) ? wdata : mem_q[addr];

endmodule

// File: rtl/vx_tag_access_assoc_chk.sv
// Simulation-only checks on the tag compare of an accepted lookup.
module vx_tag_access_assoc_chk #(
  parameter int unsigned NUM_WAYS = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic                check_i,
  input logic [NUM_WAYS-1:0] match_i
);

  // A tag may live in at most one valid way of a set.
  always @(posedge clk_i) begin
    if (rst_ni && check_i) begin
      assert ($onehot0(match_i));
    end
  end

endmodule

// File: rtl/vx_tag_victim_sel.sv
// Victim choice: lowest-index invalid way, otherwise the set's round-robin pointer.
module vx_tag_victim_sel #(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned WAY_BITS = 2
) (
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [WAY_BITS-1:0] rr_ptr_i,
  output logic [WAY_BITS-1:0] evict_way_o
);

  // Descending scan so the lowest invalid way wins.
  always_comb begin
    evict_way_o = rr_ptr_i;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      evict_way_o = valid_i[w] ? evict_way_o : WAY_BITS'(w);
    end
  end

endmodule

// File: rtl/vx_tag_access_assoc.sv
// N-way set-associative tag store for one cache bank: stage-0 lookup/fill,
// registered stage-1 hit/victim results, and a self-timed invalidate sweep.
module vx_tag_access_assoc
  import vx_tag_pkg::*;
#(
  parameter int unsigned NUM_SETS  = 64,
  parameter int unsigned NUM_WAYS  = 4,
  parameter int unsigned TAG_WIDTH = 20,
  parameter bit          WRITEBACK = 1'b0,
  localparam int unsigned SET_BITS = $clog2(NUM_SETS),
  localparam int unsigned WAY_BITS = way_bits(NUM_WAYS),
  localparam int unsigned ADDR_W   = TAG_WIDTH + SET_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 lookup,
  input  logic                 write,
  input  logic                 fill,
  input  logic [WAY_BITS-1:0]  fill_way,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 flush_req,
  output logic                 ready,
  output logic                 tag_match,
  output logic [WAY_BITS-1:0]  hit_way,
  output logic [WAY_BITS-1:0]  evict_way,
  output logic                 evict_valid,
  output logic                 evict_dirty,
  output logic [TAG_WIDTH-1:0] evict_tag
);

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  fsm_state_t          state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic                idle_s, flush_go_s, lookup_go_s, fill_go_s;
  logic [SET_BITS-1:0] set_s, ram_addr_s;
  logic [TAG_WIDTH-1:0] tag_s;
  entry_t              rd_s [NUM_WAYS];
  entry_t              wd_s [NUM_WAYS];
  entry_t              victim_e_s;
  logic [NUM_WAYS-1:0] we_s, valid_s, match_s;
  logic [WAY_BITS-1:0] hit_idx_s, rr_cur_s, victim_s;

  logic                 tag_match_q, evict_valid_q, evict_dirty_q;
  logic [WAY_BITS-1:0]  hit_way_q, evict_way_q;
  logic [TAG_WIDTH-1:0] evict_tag_q;

  assign set_s  = addr[SET_BITS-1:0];
  assign tag_s  = addr[ADDR_W-1:SET_BITS];
  assign idle_s = (state_q == IDLE);
  // A flush request wins over a lookup or fill in the same cycle.
  assign flush_go_s  = idle_s && flush_req && !stall;
  assign lookup_go_s = idle_s && lookup && !flush_req && !stall;
  assign fill_go_s   = idle_s && fill && !flush_req && !stall;
  assign ram_addr_s  = idle_s ? set_s : cnt_q;

  // Sweep sequencing: one set per unstalled cycle, then back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_go_s) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        if (stall) begin
          cnt_d = cnt_q;
        end else if (cnt_q == SET_BITS'(NUM_SETS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SET_BITS'(1);
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and sweep counter; reset restarts the sweep from set 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    VX_sp_ram #(
      .DATAW      (TAG_WIDTH + 2),
      .SIZE       (NUM_SETS),
      .NO_RWCHECK (1'b1)
    ) u_ram (
      .clk   (clk),
      .en    (!stall),
      .write (we_s[w]),
      .addr  (ram_addr_s),
      .wdata (wd_s[w]),
      .rdata (rd_s[w])
    );
    assign valid_s[w] = rd_s[w].valid;
    assign match_s[w] = rd_s[w].valid && (rd_s[w].tag == tag_s);
  end

  // Per-way write select: sweep clears, fill installs, write-hit sets dirty.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      we_s[w] = 1'b0;
      wd_s[w] = '0;
      if (!idle_s) begin
        we_s[w] = 1'b1;
      end else if (fill_go_s && (fill_way == WAY_BITS'(w))) begin
        we_s[w]       = 1'b1;
        wd_s[w].valid = 1'b1;
        wd_s[w].dirty = WRITEBACK && write;
        wd_s[w].tag   = tag_s;
      end else if (lookup_go_s && write && WRITEBACK && match_s[w]) begin
        we_s[w]       = 1'b1;
        wd_s[w]       = rd_s[w];
        wd_s[w].dirty = 1'b1;
      end else begin
        we_s[w] = 1'b0;
      end
    end
  end

  // One-hot match to index; at most one bit is set.
  always_comb begin
    hit_idx_s = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_idx_s = hit_idx_s | (match_s[w] ? WAY_BITS'(w) : WAY_BITS'(0));
    end
  end

  if (NUM_WAYS > 1) begin : g_rr
    logic [WAY_BITS-1:0] rr_q [NUM_SETS];

    // Round-robin pointer per set, advanced by fills only.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          rr_q[s] <= '0;
        end
      end else if (fill_go_s) begin
        rr_q[set_s] <= rr_q[set_s] + WAY_BITS'(1);
      end
    end

    assign rr_cur_s   = rr_q[set_s];
    assign victim_e_s = rd_s[victim_s];
  end else begin : g_no_rr
    assign rr_cur_s   = '0;
    assign victim_e_s = rd_s[0];
  end

  vx_tag_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_BITS (WAY_BITS)
  ) u_victim (
    .valid_i     (valid_s),
    .rr_ptr_i    (rr_cur_s),
    .evict_way_o (victim_s)
  );

  // Stage-1 result registers, loaded on an accepted lookup and held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_match_q   <= 1'b0;
      hit_way_q     <= '0;
      evict_way_q   <= '0;
      evict_valid_q <= 1'b0;
      evict_dirty_q <= 1'b0;
      evict_tag_q   <= '0;
    end else if (lookup_go_s) begin
      tag_match_q   <= |match_s;
      hit_way_q     <= hit_idx_s;
      evict_way_q   <= victim_s;
      evict_valid_q <= victim_e_s.valid;
      evict_dirty_q <= WRITEBACK && victim_e_s.dirty;
      evict_tag_q   <= victim_e_s.tag;
    end
  end

  assign ready       = idle_s;
  assign tag_match   = tag_match_q;
  assign hit_way     = hit_way_q;
  assign evict_way   = evict_way_q;
  assign evict_valid = evict_valid_q;
  assign evict_dirty = evict_dirty_q;
  assign evict_tag   = evict_tag_q;

  vx_tag_access_assoc_chk #(
    .NUM_WAYS (NUM_WAYS)
  ) u_chk (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .check_i (lookup_go_s),
    .match_i (match_s)
  );

endmodule
